// File: rtl/alu_mul_sequencer_if.sv
// Handshake bundle between the multiply sequencer, its requester and the
// shared ALU. The sequencer uses the slave side; the owner of the operands,
// the ALU mux and the grant arbiter sits on the master side.
interface alu_mul_sequencer_if #(
    parameter int WIDTH  = 64,
    parameter int CTRL_W = 4
);
    // Requester side
    logic              start;
    logic [WIDTH-1:0]  multiplicand;
    logic [WIDTH-1:0]  multiplier;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  product;
    logic              zero_flag;

    // Shared ALU side
    logic              alu_req;
    logic              alu_gnt;
    logic [WIDTH-1:0]  alu_data1;
    logic [WIDTH-1:0]  alu_data2;
    logic [CTRL_W-1:0] alu_control;
    logic [WIDTH-1:0]  alu_result;

    modport master (
        output start, multiplicand, multiplier, alu_gnt, alu_result,
        input  busy, done, product, zero_flag,
               alu_req, alu_data1, alu_data2, alu_control
    );

    modport slave (
        input  start, multiplicand, multiplier, alu_gnt, alu_result,
        output busy, done, product, zero_flag,
               alu_req, alu_data1, alu_data2, alu_control
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned shift-and-add multiplier that borrows the shared 64-bit ALU.
// Each granted RUN cycle issues one ADD of (acc + (mplier[0] ? mcand : 0)),
// then shifts mcand left and mplier right. RUN ends after the cycle in which
// the remaining multiplier becomes zero, so RUN length follows the multiplier's
// highest set bit. Only the low WIDTH bits of the product are kept.
module alu_mul_sequencer #(
    parameter int                WIDTH    = 64,
    parameter int                CTRL_W   = 4,
    parameter logic [CTRL_W-1:0] ALU_ADD  = 4'b0010,
    parameter logic [CTRL_W-1:0] ALU_IDLE = 4'b0000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    alu_mul_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_product;
    logic             r_zero_flag;

    logic             w_in_run;
    logic             w_can_start;
    logic             w_accept;
    logic             w_step;
    logic             w_last_step;
    logic             w_mplier_zero;

    assign w_in_run      = (r_state == S_RUN);
    assign w_can_start   = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept      = w_can_start && bus.start;
    assign w_mplier_zero = (bus.multiplier == '0);
    assign w_step        = w_in_run && bus.alu_gnt;
    // The bit about to be consumed is the last one when nothing remains above it.
    assign w_last_step   = (r_mplier[WIDTH-1:1] == '0);

    // State register; reset aborts any multiply in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a zero multiplier skips RUN and never touches the ALU.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_next = w_mplier_zero ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.alu_gnt && w_last_step) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: capture operands on accepted start, step on each granted RUN cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_product   <= '0;
            r_zero_flag <= 1'b0;
        end else if (w_accept) begin
            r_acc    <= '0;
            r_mcand  <= bus.multiplicand;
            r_mplier <= bus.multiplier;
            if (w_mplier_zero) begin
                r_product   <= '0;
                r_zero_flag <= 1'b1;
            end
        end else if (w_step) begin
            r_acc    <= bus.alu_result;
            // MSB of mcand falls off: product bits above WIDTH are discarded.
            r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            if (w_last_step) begin
                r_product   <= bus.alu_result;
                r_zero_flag <= (bus.alu_result == '0);
            end
        end
    end

    // Outputs are decoded from state and registers only, so start and gnt
    // never reach an output combinationally; during a stall they hold steady.
    assign bus.busy        = w_in_run;
    assign bus.done        = (r_state == S_DONE);
    assign bus.alu_req     = w_in_run;
    assign bus.product     = r_product;
    assign bus.zero_flag   = r_zero_flag;
    assign bus.alu_data1   = w_in_run ? r_acc : '0;
    assign bus.alu_data2   = (w_in_run && r_mplier[0]) ? r_mcand : '0;
    assign bus.alu_control = w_in_run ? ALU_ADD : ALU_IDLE;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer. A small behavioural ALU (ADD/AND)
// answers the sequencer; each multiply is checked for latency, busy length,
// product, zero flag and single-cycle done.
`timescale 1ns/1ps
module tb_alu_mul_sequencer;

    localparam int WIDTH = 64;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_IDLE = 4'b0000;

    logic i_clk;
    logic i_rst_n;
    int   n_checks;
    int   n_errors;

    alu_mul_sequencer_if #(.WIDTH(WIDTH), .CTRL_W(4)) bus_if ();

    alu_mul_sequencer #(
        .WIDTH(WIDTH), .CTRL_W(4), .ALU_ADD(ALU_ADD), .ALU_IDLE(ALU_IDLE)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus_if)
    );

    // Shared ALU stand-in: ADD or AND of the two operands.
    assign bus_if.alu_result = (bus_if.alu_control == ALU_ADD)
                               ? (bus_if.alu_data1 + bus_if.alu_data2)
                               : (bus_if.alu_data1 & bus_if.alu_data2);

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Runs one multiply. stall_mask bit c drops gnt in cycle c (cycle 1 = first
    // cycle after start). stall_d1/d2 are the ALU inputs required while stalled.
    // With mid_start, a start with other operands is pulsed in cycle 10.
    task automatic run_mul(input string name,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp_p, input logic exp_z,
                           input int exp_busy, input int exp_done_cycle,
                           input logic [31:0] stall_mask,
                           input logic [63:0] stall_d1, input logic [63:0] stall_d2,
                           input bit mid_start);
        int  busy_cnt;
        int  done_cycle;
        int  req_idle;
        bit  got_done;
        busy_cnt = 0; done_cycle = 0; req_idle = 0; got_done = 0;
        @(posedge i_clk); #1;
        bus_if.start = 1'b1;
        bus_if.multiplicand = a;
        bus_if.multiplier = b;
        @(posedge i_clk); #1;
        for (int c = 1; c <= 200 && !got_done; c++) begin
            bus_if.start = 1'b0;
            if (mid_start && c == 10) begin
                bus_if.start = 1'b1;
                bus_if.multiplicand = 64'd3;
                bus_if.multiplier = 64'd3;
            end
            bus_if.alu_gnt = !(c < 32 && stall_mask[c]);
            if (c < 32 && stall_mask[c]) begin
                check_eq({name, " stall_data1"}, bus_if.alu_data1, stall_d1);
                check_eq({name, " stall_data2"}, bus_if.alu_data2, stall_d2);
                check_eq({name, " stall_busy"}, {63'd0, bus_if.busy}, 64'd1);
            end
            if (bus_if.busy) busy_cnt++;
            if (bus_if.alu_req != bus_if.busy) req_idle++;
            if (bus_if.done) begin
                got_done = 1;
                done_cycle = c;
            end else begin
                @(posedge i_clk); #1;
            end
        end
        bus_if.start = 1'b0;
        bus_if.alu_gnt = 1'b1;
        check_eq({name, " done_seen"}, {63'd0, got_done}, 64'd1);
        check_eq({name, " done_cycle"}, 64'(done_cycle), 64'(exp_done_cycle));
        check_eq({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check_eq({name, " req_eq_busy"}, 64'(req_idle), 64'd0);
        check_eq({name, " product"}, bus_if.product, exp_p);
        check_eq({name, " zero_flag"}, {63'd0, bus_if.zero_flag}, {63'd0, exp_z});
        @(posedge i_clk); #1;
        check_eq({name, " done_pulse"}, {63'd0, bus_if.done}, 64'd0);
        check_eq({name, " product_hold"}, bus_if.product, exp_p);
        $display("mul %s: a=0x%016h b=0x%016h product=0x%016h zero=%0b done_cycle=%0d busy=%0d",
                 name, a, b, bus_if.product, bus_if.zero_flag, done_cycle, busy_cnt);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        i_rst_n = 1'b0;
        bus_if.start = 1'b0;
        bus_if.multiplicand = '0;
        bus_if.multiplier = '0;
        bus_if.alu_gnt = 1'b1;
        #2;
        check_eq("rst busy", {63'd0, bus_if.busy}, 64'd0);
        check_eq("rst done", {63'd0, bus_if.done}, 64'd0);
        check_eq("rst req", {63'd0, bus_if.alu_req}, 64'd0);
        check_eq("rst product", bus_if.product, 64'd0);
        check_eq("rst zero", {63'd0, bus_if.zero_flag}, 64'd0);
        check_eq("rst control", {60'd0, bus_if.alu_control}, {60'd0, ALU_IDLE});
        @(posedge i_clk); #3;
        i_rst_n = 1'b1;

        // 1: 6*7 with grant held high; multiplier 0b111 needs three ADDs.
        run_mul("t1", 64'd6, 64'd7, 64'd42, 1'b0, 3, 4, 32'd0, 64'd0, 64'd0, 1'b0);
        // 2: zero multiplier finishes straight away, ALU untouched.
        run_mul("t2", 64'd5, 64'd0, 64'd0, 1'b1, 0, 1, 32'd0, 64'd0, 64'd0, 1'b0);
        // 3: 5*3 with gnt low in cycles 2-3; after step 1 acc=5, mcand=10, mplier=1.
        run_mul("t3", 64'd5, 64'd3, 64'd15, 1'b0, 4, 5, 32'b1100, 64'd5, 64'd10, 1'b0);
        // 4: 2^63*2 wraps to zero.
        run_mul("t4", 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1, 2, 3, 32'd0, 64'd0, 64'd0, 1'b0);
        // 5: (2^64-1)^2 mod 2^64 = 1; a start in mid-RUN must be ignored.
        run_mul("t5", {64{1'b1}}, {64{1'b1}}, 64'd1, 1'b0, 64, 65, 32'd0, 64'd0, 64'd0, 1'b1);

        // 6: reset during RUN cycle 2 of 6*7 aborts immediately.
        @(posedge i_clk); #1;
        bus_if.start = 1'b1;
        bus_if.multiplicand = 64'd6;
        bus_if.multiplier = 64'd7;
        @(posedge i_clk); #1;
        bus_if.start = 1'b0;
        @(posedge i_clk); #1;
        check_eq("t6 busy_before_rst", {63'd0, bus_if.busy}, 64'd1);
        i_rst_n = 1'b0;
        #1;
        check_eq("t6 busy_rst", {63'd0, bus_if.busy}, 64'd0);
        check_eq("t6 req_rst", {63'd0, bus_if.alu_req}, 64'd0);
        check_eq("t6 data1_rst", bus_if.alu_data1, 64'd0);
        check_eq("t6 product_rst", bus_if.product, 64'd0);
        check_eq("t6 control_rst", {60'd0, bus_if.alu_control}, {60'd0, ALU_IDLE});
        @(posedge i_clk); #2;
        i_rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk); #1;
            check_eq("t6 no_done", {63'd0, bus_if.done}, 64'd0);
        end
        $display("reset abort: done stayed low after release");
        run_mul("t6r", 64'd6, 64'd7, 64'd42, 1'b0, 3, 4, 32'd0, 64'd0, 64'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
